// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the gray-pointer FIFO write and read controllers.
// The conversions work on 32-bit values. Callers zero-extend their AW+1 bit
// pointer on the way in and size-cast the result back on the way out.
// Upper bits that are zero on input stay zero through both conversions.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  // Address width for a power-of-two depth; pointers carry one extra wrap bit
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Binary to reflected gray code
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running xor-prefix from the MSB down
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for the dual-clock gray-pointer FIFO.
// This block produces the RAM write enable and address, the gray write pointer
// sent to the read domain, the full and almost-full flags, a conservative fill
// level, and a sticky overflow flag.
// The read pointer arrives already synchronised. Because it lags the true read
// position, the level and the flags can only over-estimate occupancy.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_MARGIN = 2,
  localparam int AW           = addr_width(DEPTH),
  localparam int PW           = AW + 1
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          wr_rq,
  input  logic [PW-1:0] wsync_ptr2,
  input  logic          ovf_clr,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [PW-1:0] wptr,
  output logic          full,
  output logic          almost_full,
  output logic [PW-1:0] wlevel,
  output logic          overflow
);

  // Reject illegal configurations at elaboration time.
  // WIDTH is carried only for consistency with the FIFO top.
  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_params
    $fatal(1, "fifo_wr_ctrl: illegal WIDTH/DEPTH/AFULL_MARGIN");
  end

  localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;
  logic          push;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_wrapped;

  // Next-state computation.
  // A push and a read-pointer advance in the same cycle are both folded in here,
  // so the level holds and full stays low.
  always_comb begin
    push         = wr_rq & ~full_q;
    wbin_d       = wbin_q + PW'(push);
    wptr_d       = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    rbin         = PW'(gray2bin(PTR_MAX_W'(wsync_ptr2)));
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    // In gray code, that means the top two bits are inverted and the rest are equal.
    rptr_wrapped = {~wsync_ptr2[AW:AW-1], wsync_ptr2[AW-2:0]};
    full_d       = (wptr_d == rptr_wrapped);
    wlevel_d     = wbin_d - rbin;
    afull_d      = (wlevel_d >= AFULL_THRESH);
    // If a new overflow and a clear land on the same cycle, the new overflow wins
    overflow_d   = (wr_rq & full_q) | (overflow_q & ~ovf_clr);
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q     <= '0;
      wptr_q     <= '0;
      wlevel_q   <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wptr_q     <= wptr_d;
      wlevel_q   <= wlevel_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
    end
  end

  assign wen         = push;
  assign waddr       = wbin_q[AW-1:0];
  assign wptr        = wptr_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wlevel      = wlevel_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: scoreboard against an occupancy-level reference model.
// The stimulus process drives one transaction per cycle and queues the expected
// response; a monitor process pops it and checks both the combinational outputs
// before the edge and the registered outputs after it.
module tb_fifo_wr_ctrl;

  localparam int WIDTH        = 4;
  localparam int DEPTH        = 8;
  localparam int AFULL_MARGIN = 2;
  localparam int AW           = 3;
  localparam int PW           = 4;

  logic          w_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_rq = 1'b0;
  logic [PW-1:0] wsync_ptr2 = '0;
  logic          ovf_clr = 1'b0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          full;
  logic          almost_full;
  logic [PW-1:0] wlevel;
  logic          overflow;

  fifo_wr_ctrl #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .w_clk      (w_clk),
    .rst_n      (rst_n),
    .wr_rq      (wr_rq),
    .wsync_ptr2 (wsync_ptr2),
    .ovf_clr    (ovf_clr),
    .wen        (wen),
    .waddr      (waddr),
    .wptr       (wptr),
    .full       (full),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    int            id;
    logic          wen;
    logic [AW-1:0] waddr_pre;
    logic [PW-1:0] wptr;
    logic [AW-1:0] waddr;
    logic          full;
    logic          afull;
    logic [PW-1:0] lvl;
    logic          ovf;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: total writes and reads as plain integers.
  // The flags are derived from the occupancy m_wr - m_rd.
  int   m_wr   = 0;
  int   m_rd   = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;
  int   txn    = 0;

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 ** PW));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction: wr request, read count the synchroniser now shows, overflow clear
  task automatic drive(input logic wr, input int rd_new, input logic clr);
    exp_t e;
    int   occ;
    @(posedge w_clk);
    #2;
    wr_rq      = wr;
    ovf_clr    = clr;
    wsync_ptr2 = gray_of(rd_new);
    e.id        = txn++;
    e.wen       = wr && !m_full;
    e.waddr_pre = AW'(m_wr % DEPTH);
    m_ovf       = (wr && m_full) || (m_ovf && !clr);
    if (e.wen) m_wr++;
    m_rd    = rd_new;
    occ     = m_wr - m_rd;
    m_full  = (occ == DEPTH);
    e.wptr  = gray_of(m_wr);
    e.waddr = AW'(m_wr % DEPTH);
    e.full  = m_full;
    e.afull = (occ >= DEPTH - AFULL_MARGIN);
    e.lvl   = PW'(occ);
    e.ovf   = m_ovf;
    q.push_back(e);
  endtask

  // Wait for the scoreboard to empty, bounded, then let the last check complete
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge w_clk);
    chk("drain_queue_empty", q.size(), 0);
    @(posedge w_clk);
    #3;
    wr_rq   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag, input logic exp_wen);
    chk({tag, "_wen"},      wen,         exp_wen);
    chk({tag, "_waddr"},    waddr,       0);
    chk({tag, "_wptr"},     wptr,        0);
    chk({tag, "_full"},     full,        0);
    chk({tag, "_afull"},    almost_full, 0);
    chk({tag, "_wlevel"},   wlevel,      0);
    chk({tag, "_overflow"}, overflow,    0);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 1'b0; m_ovf = 1'b0;
    wsync_ptr2 = '0;
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge
  initial begin : monitor
    exp_t          e;
    logic [PW-1:0] prev_wptr;
    forever begin
      @(negedge w_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        prev_wptr = wptr;
        chk("wen",       wen,   e.wen);
        chk("waddr_pre", waddr, e.waddr_pre);
        @(posedge w_clk);
        #1;
        chk("wptr",      wptr,        e.wptr);
        chk("waddr",     waddr,       e.waddr);
        chk("full",      full,        e.full);
        chk("afull",     almost_full, e.afull);
        chk("wlevel",    wlevel,      e.lvl);
        chk("overflow",  overflow,    e.ovf);
        if (e.wen) chk("wptr_one_bit", $countones(wptr ^ prev_wptr), 1);
        $display("txn %0d wen=%0b wptr=%b waddr=%0d full=%0b af=%0b lvl=%0d ovf=%0b",
                 e.id, e.wen, wptr, waddr, full, almost_full, wlevel, overflow);
      end
    end
  end

  initial begin : stimulus
    // 1. Reset with a request pending: wen follows wr_rq, everything else is zero
    rst_n = 1'b0; wr_rq = 1'b1;
    repeat (3) @(posedge w_clk);
    #3;
    check_reset_state("reset", 1'b1);
    wr_rq = 1'b0;
    model_reset();
    @(posedge w_clk);
    #2;
    rst_n = 1'b1;

    drive(1'b1, 0, 1'b0);                              // first push
    // 2. Pushes up to level 6: almost_full rises
    repeat (5) drive(1'b1, 0, 1'b0);
    // 3. Fill to 8, then one request while full
    repeat (2) drive(1'b1, 0, 1'b0);
    drive(1'b1, 0, 1'b0);                              // dropped, sets overflow
    // 4. One read arrives, no push
    drive(1'b0, 1, 1'b0);
    // 5. Clear overflow with no request, refill, then clear together with a request while full
    drive(1'b0, 1, 1'b1);
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 1, 1'b1);
    // 6. Level 3, then stream 40 pushes with the read side three behind
    drive(1'b0, m_wr - 3, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, m_wr + 1 - 3, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic wr, clr;
      int   rd;
      wr  = ($urandom_range(0, 99) < 60);
      clr = ($urandom_range(0, 9) == 0);
      rd  = (m_rd < m_wr && $urandom_range(0, 1) == 1) ? m_rd + 1 : m_rd;
      drive(wr, rd, clr);
    end

    // Asynchronous reset mid-operation
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset", 1'b0);
    model_reset();
    @(posedge w_clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) drive(($urandom_range(0, 3) != 0), 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, got hang expected completion");
    $fatal(1, "watchdog timeout");
  end

endmodule
